// File: rtl/ds2411_id_check.sv
// Sequencer/validator behind the DS2411 ROM reader: drives go, retries, CRC-checks and latches the ID.
// Optional family-byte check enabled by defining DS2411_FAMILY_CHECK_EN.
`timescale 1ns/1ps

module ds2411_id_check #(
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned GO_HOLD_CYCLES = 200,
  parameter logic [7:0]  FAMILY_CODE    = 8'h01
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        rd_go,
  input  logic        rd_done,
  input  logic        rd_error,
  input  logic [63:0] rd_result,
  output logic        busy,
  output logic        id_valid,
  output logic        crc_err,
  output logic        no_dev,
  output logic [7:0]  family,
  output logic [47:0] serial,
  output logic [3:0]  attempts
);

  localparam int unsigned TMO_W  = 21;
  localparam int unsigned HOLD_W = 16;
  localparam int unsigned BIT_W  = 6;

`ifdef DS2411_FAMILY_CHECK_EN
  localparam bit FAM_CHK = 1'b1;
`else
  localparam bit FAM_CHK = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_GO, S_WAIT, S_CRC, S_FAIL, S_PASS} state_t;

  state_t             state;
  logic [TMO_W-1:0]   tmo;
  logic [HOLD_W-1:0]  hold;
  logic [BIT_W-1:0]   bit_idx;
  logic [63:0]        rom;
  logic [7:0]         crc;
  logic               fail_nodev;
  logic               done_m, done_s, done_q;
  logic               err_m, err_s, err_q;
  logic               done_rise, err_rise, crc_fb, fam_bad;

  // Two-flop synchronisers plus one history flop for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      {done_m, done_s, done_q} <= 3'b000;
      {err_m, err_s, err_q}    <= 3'b000;
    end else begin
      {done_m, done_s, done_q} <= {rd_done, done_m, done_s};
      {err_m, err_s, err_q}    <= {rd_error, err_m, err_s};
    end
  end

  assign done_rise = done_s & ~done_q;
  assign err_rise  = err_s & ~err_q;
  assign crc_fb    = crc[0] ^ rom[bit_idx];
  assign fam_bad   = FAM_CHK && (rom[7:0] != FAMILY_CODE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      rd_go      <= 1'b0;
      busy       <= 1'b0;
      id_valid   <= 1'b0;
      crc_err    <= 1'b0;
      no_dev     <= 1'b0;
      family     <= 8'h00;
      serial     <= 48'h0;
      attempts   <= 4'd0;
      tmo        <= '0;
      hold       <= '0;
      bit_idx    <= '0;
      rom        <= 64'h0;
      crc        <= 8'h00;
      fail_nodev <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            id_valid <= 1'b0;
            crc_err  <= 1'b0;
            no_dev   <= 1'b0;
            attempts <= 4'd1;
            rom      <= 64'h0;
            rd_go    <= 1'b1;
            hold     <= '0;
            state    <= S_GO;
          end
        end
        S_GO: begin
          if (hold == HOLD_W'(GO_HOLD_CYCLES - 1)) begin
            rd_go <= 1'b0;
            tmo   <= '0;
            state <= S_WAIT;
          end else begin
            hold <= hold + 1'b1;
          end
        end
        // Error takes priority over a simultaneous done edge
        S_WAIT: begin
          if (tmo != '1) tmo <= tmo + 1'b1;
          if (err_rise || tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            fail_nodev <= 1'b1;
            state      <= S_FAIL;
          end else if (done_rise) begin
            rom     <= rd_result;
            crc     <= 8'h00;
            bit_idx <= '0;
            state   <= S_CRC;
          end
        end
        S_CRC: begin
          if (bit_idx != BIT_W'(56)) begin
            crc     <= {1'b0, crc[7:1]} ^ (crc_fb ? 8'h8C : 8'h00);
            bit_idx <= bit_idx + 1'b1;
          end else if (rom == 64'h0) begin
            fail_nodev <= 1'b1;
            state      <= S_FAIL;
          end else if (crc != rom[63:56] || fam_bad) begin
            fail_nodev <= 1'b0;
            state      <= S_FAIL;
          end else begin
            state <= S_PASS;
          end
        end
        S_FAIL: begin
          if ({1'b0, attempts} <= 5'(MAX_RETRY)) begin
            attempts <= attempts + 1'b1;
            rd_go    <= 1'b1;
            hold     <= '0;
            state    <= S_GO;
          end else begin
            busy    <= 1'b0;
            no_dev  <= fail_nodev;
            crc_err <= ~fail_nodev;
            family  <= rom[7:0];
            serial  <= rom[55:8];
            state   <= S_IDLE;
          end
        end
        S_PASS: begin
          busy     <= 1'b0;
          id_valid <= 1'b1;
          family   <= rom[7:0];
          serial   <= rom[55:8];
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ds2411_id_check.sv
// Scoreboard bench for ds2411_id_check with a behavioural reader that follows a per-attempt plan.
`timescale 1ns/1ps

module tb_ds2411_id_check;

  localparam int unsigned TMO   = 1000;
  localparam int unsigned HOLD  = 20;
  localparam int unsigned RETRY = 3;
  localparam logic [7:0]  FAM   = 8'h02;

  logic        clk = 1'b0;
  logic        reset_n, start, rd_go, rd_done, rd_error;
  logic [63:0] rd_result;
  logic        busy, id_valid, crc_err, no_dev;
  logic [7:0]  family;
  logic [47:0] serial;
  logic [3:0]  attempts;

  ds2411_id_check #(
    .TIMEOUT_CYCLES(TMO), .MAX_RETRY(RETRY), .GO_HOLD_CYCLES(HOLD), .FAMILY_CODE(FAM)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .rd_go(rd_go), .rd_done(rd_done),
    .rd_error(rd_error), .rd_result(rd_result), .busy(busy), .id_valid(id_valid),
    .crc_err(crc_err), .no_dev(no_dev), .family(family), .serial(serial), .attempts(attempts)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv, ce, nd;
    logic [7:0]  fam;
    logic [47:0] ser;
    logic [3:0]  att;
    int          pulses;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Dallas CRC-8, reflected polynomial 0x8C, byte at a time LSB first
  function automatic logic [7:0] crc8(input logic [55:0] d);
    logic [7:0] c = 8'h00;
    logic [7:0] b;
    for (int i = 0; i < 7; i++) begin
      b = d[i*8 +: 8];
      for (int k = 0; k < 8; k++) begin
        if ((c[0] ^ b[0]) == 1'b1) c = (c >> 1) ^ 8'h8C;
        else c = c >> 1;
        b = b >> 1;
      end
    end
    return c;
  endfunction

  function automatic exp_t mk_exp(input logic iv, ce, nd, input logic [7:0] fam,
                                  input logic [47:0] ser, input logic [3:0] att, input int p);
    exp_t e;
    e.iv = iv; e.ce = ce; e.nd = nd; e.fam = fam; e.ser = ser; e.att = att; e.pulses = p;
    return e;
  endfunction

  // Reader model: plan 0 = done with roms[i], 1 = error, 2 = silent
  int          plan[4];
  logic [63:0] roms[4];
  int          pulses = 0;

  initial begin
    int idx;
    rd_done = 1'b0; rd_error = 1'b0; rd_result = 64'h0;
    forever begin
      @(posedge rd_go);
      pulses++;
      @(negedge clk);
      rd_done = 1'b0; rd_error = 1'b0;
      @(negedge rd_go);
      repeat (5) @(negedge clk);
      idx = (pulses > 4) ? 3 : pulses - 1;
      case (plan[idx])
        0: begin rd_result = roms[idx]; rd_done = 1'b1; end
        1: rd_error = 1'b1;
        default: ;
      endcase
    end
  end

  task automatic set_plan(input int p0, p1, p2, p3, input logic [63:0] r);
    plan[0] = p0; plan[1] = p1; plan[2] = p2; plan[3] = p3;
    for (int i = 0; i < 4; i++) roms[i] = r;
  endtask

  task automatic run(input string name, input exp_t e, input bit extra_start, output int elapsed);
    exp_t got;
    int   n = 0;
    pulses = 0;
    sb.push_back(e);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (busy !== 1'b0 && n < 40000) begin
      if (extra_start && n == 100) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n++;
    end
    elapsed = n;
    got = sb.pop_front();
    if (busy !== 1'b0) begin
      check_val({name, " done_wait"}, 64'(busy), 64'(0));
    end else begin
      check_val({name, " id_valid"}, 64'(id_valid), 64'(got.iv));
      check_val({name, " crc_err"},  64'(crc_err),  64'(got.ce));
      check_val({name, " no_dev"},   64'(no_dev),   64'(got.nd));
      check_val({name, " family"},   64'(family),   64'(got.fam));
      check_val({name, " serial"},   64'(serial),   64'(got.ser));
      check_val({name, " attempts"}, 64'(attempts), 64'(got.att));
      check_val({name, " go_pulses"}, 64'(pulses),  64'(got.pulses));
    end
  endtask

  localparam logic [63:0] ROM_A = 64'hA2_00000001B81C_02;

  initial begin
    logic [63:0] rom_f1, rom_bad;
    int el;
    start = 1'b0;
    reset_n = 1'b0;
    set_plan(2, 2, 2, 2, 64'h0);
    repeat (3) @(negedge clk);
    check_val("rst busy", 64'(busy), 64'(0));
    check_val("rst rd_go", 64'(rd_go), 64'(0));
    check_val("rst flags", 64'({id_valid, crc_err, no_dev}), 64'(0));
    check_val("rst id", 64'({family, serial}), 64'(0));
    check_val("rst attempts", 64'(attempts), 64'(0));
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    set_plan(0, 0, 0, 0, ROM_A);
    run("good", mk_exp(1, 0, 0, 8'h02, 48'h00000001B81C, 4'd1, 1), 1'b0, el);

    rom_f1 = {crc8(56'h00000001B81C01), 56'h00000001B81C01};
    set_plan(0, 0, 0, 0, rom_f1);
`ifdef DS2411_FAMILY_CHECK_EN
    run("family", mk_exp(0, 1, 0, 8'h01, 48'h00000001B81C, 4'd4, 4), 1'b0, el);
`else
    run("family", mk_exp(1, 0, 0, 8'h01, 48'h00000001B81C, 4'd1, 1), 1'b0, el);
`endif

    rom_bad = ROM_A ^ 64'h100;
    set_plan(0, 0, 0, 0, rom_bad);
    run("badcrc", mk_exp(0, 1, 0, 8'h02, 48'h00000001B81D, 4'd4, 4), 1'b0, el);

    set_plan(1, 0, 0, 0, ROM_A);
    run("retry", mk_exp(1, 0, 0, 8'h02, 48'h00000001B81C, 4'd2, 2), 1'b1, el);

    set_plan(2, 2, 2, 2, ROM_A);
    run("timeout", mk_exp(0, 0, 1, 8'h00, 48'h0, 4'd4, 4), 1'b0, el);
    check_val("timeout span_lo", 64'(el >= 4 * 1000), 64'(1));
    check_val("timeout span_hi", 64'(el <= 4 * 1300), 64'(1));

    set_plan(0, 0, 0, 0, 64'h0);
    run("zero", mk_exp(0, 0, 1, 8'h00, 48'h0, 4'd4, 4), 1'b0, el);

    // Reset while waiting on a silent reader
    set_plan(2, 2, 2, 2, ROM_A);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (100) @(negedge clk);
    check_val("midrun busy", 64'(busy), 64'(1));
    reset_n = 1'b0;
    #1;
    check_val("midrun rst busy", 64'(busy), 64'(0));
    check_val("midrun rst go", 64'(rd_go), 64'(0));
    check_val("midrun rst attempts", 64'(attempts), 64'(0));
    check_val("midrun rst flags", 64'({id_valid, crc_err, no_dev}), 64'(0));
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    set_plan(0, 0, 0, 0, ROM_A);
    run("recover", mk_exp(1, 0, 0, 8'h02, 48'h00000001B81C, 4'd1, 1), 1'b0, el);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
